// File: rtl/mux3_rr_sched.sv
// mux3_rr_sched
// -----------------------------------------------------------------------------
// Round-robin scheduler for a shared 3:1 single-bit select datapath. Three
// requesters (A, B, C) compete for the mux. The block drives a registered
// one-hot grant and a matching select code for the team's priority-encoded
// 3:1 mux. It also registers the selected data bit together with its source
// tag and a valid flag.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   synchronous, active-high reset
//   req[2:0]   in   request lines: bit2=A, bit1=B, bit0=C
//   a, b, c    in   data bits from A, B, C
//   gnt[2:0]   out  registered one-hot grant, same bit order as req
//   sel[1:0]   out  registered mux select: A=2'b10, B=2'b01, C=2'b00
//   sel_valid  out  high when gnt is nonzero
//   q          out  registered selected data bit
//   q_valid    out  q holds data sampled under a grant
//   q_src[1:0] out  owner of q, same encoding as sel
//   dbg_state  out  current FSM state, for checkers
//
// Handshake: a requester holds req high for as long as it wants the mux. A
// grant is registered one cycle after the request is seen. An owner keeps the
// grant until it drops req or has held it for HOLD_MAX consecutive cycles.
// Requests from other requesters never take the grant away before that point.
//
// Optional build macro: MUX3_RR_GUARD_CYCLE_EN. When it is defined, a handoff
// between two different owners passes through one GUARD cycle with gnt=0.
// -----------------------------------------------------------------------------
module mux3_rr_sched #(
    parameter int HOLD_MAX = 4,  // legal range 1..7
    parameter int CNT_W    = 3   // must be wide enough to hold HOLD_MAX-1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] req,
    input  logic       a,
    input  logic       b,
    input  logic       c,
    output logic [2:0] gnt,
    output logic [1:0] sel,
    output logic       sel_valid,
    output logic       q,
    output logic       q_valid,
    output logic [1:0] q_src,
    output logic [1:0] dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1
`ifdef MUX3_RR_GUARD_CYCLE_EN
        ,
        GUARD = 2'd2
`endif
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);

    state_t           state, state_n;
    logic [2:0]       gnt_n;
    logic [CNT_W-1:0] hold_cnt, hold_n;
    // The last owner is kept as a one-hot vector. It is reset to C, so the
    // first priority order after reset is A, B, C.
    logic [2:0]       last, last_n;
    logic [2:0]       winner;

    // Round-robin pick. After owner X the priority is X+1, X+2, X, moving
    // cyclically A -> B -> C -> A. In terms of bit positions this is
    // 2 -> 1 -> 0 -> 2.
    function automatic logic [2:0] rr_pick(input logic [2:0] r, input logic [2:0] l);
        logic [2:0] w;
        w = 3'b000;
        case (l)
            3'b100: begin  // last A: B, C, A
                if      (r[1]) w = 3'b010;
                else if (r[0]) w = 3'b001;
                else if (r[2]) w = 3'b100;
            end
            3'b010: begin  // last B: C, A, B
                if      (r[0]) w = 3'b001;
                else if (r[2]) w = 3'b100;
                else if (r[1]) w = 3'b010;
            end
            default: begin // last C: A, B, C
                if      (r[2]) w = 3'b100;
                else if (r[1]) w = 3'b010;
                else if (r[0]) w = 3'b001;
            end
        endcase
        return w;
    endfunction

    function automatic logic [1:0] sel_code(input logic [2:0] g);
        logic [1:0] s;
        s = 2'b00;
        if (g[2])      s = 2'b10;
        else if (g[1]) s = 2'b01;
        return s;
    endfunction

    assign winner = rr_pick(req, last);

    // Next-state and next-grant logic.
    always_comb begin
        state_n = state;
        gnt_n   = gnt;
        hold_n  = hold_cnt;
        last_n  = last;
        case (state)
            GRANT: begin
                if (((req & gnt) != 3'b000) && (hold_cnt < HOLD_LAST)) begin
                    hold_n = hold_cnt + 1'b1;
                end else if (req == 3'b000) begin
                    gnt_n   = 3'b000;
                    hold_n  = '0;
                    state_n = IDLE;
                end else begin
                    // Release with at least one request pending. At this point
                    // last equals the current owner, so the owner is ranked
                    // lowest. It wins only when it is the sole requester
                    // after a timeout, which is a re-grant.
                    hold_n = '0;
`ifdef MUX3_RR_GUARD_CYCLE_EN
                    if (winner != gnt) begin
                        gnt_n   = 3'b000;
                        state_n = GUARD;
                    end else begin
                        gnt_n  = winner;
                        last_n = winner;
                    end
`else
                    gnt_n  = winner;
                    last_n = winner;
`endif
                end
            end
            default: begin
                // IDLE, and GUARD when it is built in. Both arbitrate with
                // the req value present in this cycle.
                gnt_n  = 3'b000;
                hold_n = '0;
                if (req != 3'b000) begin
                    gnt_n   = winner;
                    last_n  = winner;
                    state_n = GRANT;
                end else begin
                    state_n = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            gnt      <= 3'b000;
            sel      <= 2'b00;
            hold_cnt <= '0;
            last     <= 3'b001;
        end else begin
            state    <= state_n;
            gnt      <= gnt_n;
            sel      <= sel_code(gnt_n);
            hold_cnt <= hold_n;
            last     <= last_n;
        end
    end

    assign sel_valid = (gnt != 3'b000);

    // Data stage. q captures the input selected by the current sel. q and
    // q_src keep their previous values in cycles without a grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            q       <= 1'b0;
            q_valid <= 1'b0;
            q_src   <= 2'b00;
        end else begin
            q_valid <= sel_valid;
            if (sel_valid) begin
                q_src <= sel;
                case (sel)
                    2'b10:   q <= a;
                    2'b01:   q <= b;
                    default: q <= c;
                endcase
            end
        end
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_mux3_rr_sched.sv
// Testbench for mux3_rr_sched. A reference model tracks the owner index
// (0=A, 1=B, 2=C), the run length and the last owner. It computes the expected
// grant, select and data outputs each cycle. Every cycle checks all outputs.
module tb_mux3_rr_sched;

  localparam int HOLD_MAX = 4;
  localparam int WAIT_MAX = 2 * HOLD_MAX + 1;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] req;
  logic       a, b, c;
  logic [2:0] gnt;
  logic [1:0] sel;
  logic       sel_valid;
  logic       q;
  logic       q_valid;
  logic [1:0] q_src;
  logic [1:0] dbg_state;

  int tests = 0;
  int fails = 0;

  // Reference model state.
  int         m_own;   // -1 means no owner
  int         m_run;   // consecutive grant cycles of the current owner
  int         m_last;  // last owner whose grant started
  logic       m_qv, m_q;
  logic [1:0] m_qsrc;

  int         c_wait;
  bit         starv;

  mux3_rr_sched #(.HOLD_MAX(HOLD_MAX), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .req(req), .a(a), .b(b), .c(c),
    .gnt(gnt), .sel(sel), .sel_valid(sel_valid),
    .q(q), .q_valid(q_valid), .q_src(q_src), .dbg_state(dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  function automatic logic [1:0] code_of(input int i);
    if (i == 0) return 2'b10;
    if (i == 1) return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit rq(input logic [2:0] r, input int i);
    return r[2-i];
  endfunction

  // Priority after owner l is l+1, l+2, l (mod 3).
  function automatic int pick(input logic [2:0] r, input int l);
    for (int k = 1; k <= 3; k++) begin
      int i;
      i = (l + k) % 3;
      if (rq(r, i)) return i;
    end
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_own  = -1;
    m_run  = 0;
    m_last = 2;
    m_qv   = 1'b0;
    m_q    = 1'b0;
    m_qsrc = 2'b00;
  endtask

  // Drive one cycle of inputs, advance the model at the edge, then check.
  task automatic cyc(input logic [2:0] r, input logic av, input logic bv,
                     input logic cv, input logic rs);
    int w;
    logic [2:0] eg;
    req = r; a = av; b = bv; c = cv; rst = rs;
    @(posedge clk);
    if (rs) begin
      model_reset();
    end else begin
      if (m_own >= 0) begin
        m_qv   = 1'b1;
        m_q    = (m_own == 0) ? av : (m_own == 1) ? bv : cv;
        m_qsrc = code_of(m_own);
      end else begin
        m_qv = 1'b0;
      end
      if (m_own < 0) begin
        w = pick(r, m_last);
        if (w >= 0) begin
          m_own = w; m_run = 1; m_last = w;
        end
      end else if (rq(r, m_own) && m_run < HOLD_MAX) begin
        m_run++;
      end else begin
        w = pick(r, m_own);
        if (w < 0) m_own = -1;
`ifdef MUX3_RR_GUARD_CYCLE_EN
        else if (w != m_own) m_own = -1;
`endif
        else begin
          m_own = w; m_run = 1; m_last = w;
        end
      end
    end
    #1;
    eg = (m_own < 0) ? 3'b000 : (3'b100 >> m_own);
    chk("gnt", {1'b0, gnt}, {1'b0, eg});
    chk("sel", {2'b0, sel}, {2'b0, (m_own < 0) ? 2'b00 : code_of(m_own)});
    chk("sel_valid", {3'b0, sel_valid}, {3'b0, (m_own >= 0)});
    chk("q_valid", {3'b0, q_valid}, {3'b0, m_qv});
    chk("q", {3'b0, q}, {3'b0, m_q});
    chk("q_src", {2'b0, q_src}, {2'b0, m_qsrc});
    chk("gnt_onehot", {3'b0, ($countones(gnt) <= 1)}, 4'd1);
    if (starv) begin
      if (r[0] && !gnt[0]) c_wait++;
      else c_wait = 0;
      chk("c_wait_bound", {3'b0, (c_wait <= WAIT_MAX)}, 4'd1);
    end
  endtask

  initial begin
    model_reset();
    starv  = 0;
    c_wait = 0;
    req = 3'b000; a = 0; b = 0; c = 0; rst = 1;

    // reset
    cyc(3'b000, 0, 0, 0, 1);
    cyc(3'b000, 0, 0, 0, 1);
    cyc(3'b000, 0, 0, 0, 0);

    // all three requesting: A x4, B x4, C x4, A ...
    cyc(3'b111, 1, 0, 1, 0);
    chk("first_grant_a", {1'b0, gnt}, 4'b0100);
    for (int i = 0; i < 15; i++) cyc(3'b111, 1'($urandom), 1'($urandom), 1'($urandom), 0);
    for (int i = 0; i < 3; i++) cyc(3'b000, 0, 0, 0, 0);

    // B pulse of 2 cycles from idle
    cyc(3'b010, 0, 1, 0, 0);
    cyc(3'b010, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(3'b000, 0, 1, 0, 0);

    // C alone for 10 cycles: continuous grant via re-grants
    for (int i = 0; i < 10; i++) begin
      cyc(3'b001, 0, 0, 1'(i), 0);
      chk("c_alone", {1'b0, gnt}, 4'b0001);
    end
    for (int i = 0; i < 2; i++) cyc(3'b000, 0, 0, 0, 0);

    // A then B with a=1 and b toggling
    for (int i = 0; i < 12; i++) cyc(3'b110, 1, 1'(i), 0, 0);
    for (int i = 0; i < 2; i++) cyc(3'b000, 0, 0, 0, 0);

    // reset pulse mid-grant of B, then restart order at A
    cyc(3'b010, 1, 1, 1, 0);
    cyc(3'b010, 1, 1, 1, 0);
    cyc(3'b010, 1, 1, 1, 1);
    chk("rst_gnt_zero", {1'b0, gnt}, 4'b0000);
    chk("rst_qv_zero", {3'b0, q_valid}, 4'd0);
    cyc(3'b111, 1, 1, 1, 0);
    chk("restart_at_a", {1'b0, gnt}, 4'b0100);
    for (int i = 0; i < 6; i++) cyc(3'b111, 1'($urandom), 1'($urandom), 1'($urandom), 0);

    // starvation: random req with C held high
    starv  = 1;
    c_wait = 0;
    for (int i = 0; i < 100; i++)
      cyc(3'($urandom_range(0, 7)) | 3'b001, 1'($urandom), 1'($urandom), 1'($urandom), 0);
    starv = 0;

    // fully random traffic
    for (int i = 0; i < 200; i++)
      cyc(3'($urandom_range(0, 7)), 1'($urandom), 1'($urandom), 1'($urandom),
          ($urandom_range(0, 49) == 0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mux3_rr_sched.md
Name: mux3_rr_sched

Overview:
- Round-robin scheduler that shares a 3:1 single-bit select datapath between three requesters A, B and C.
- Arbitrates the request lines and drives a one-hot grant and a `sel[1:0]` code compatible with the team's priority-encoded 3:1 mux.
- Registers the selected data bit with source tag and valid.
- Sits between requester logic and the shared mux output stage.

Parameters:
- HOLD_MAX, 4, maximum consecutive grant cycles per ownership (legal range 1..7).
- CNT_W, 3, width of the hold counter; must hold HOLD_MAX-1.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  3  request lines: bit2=A, bit1=B, bit0=C.
- a  input  1  data bit from A.
- b  input  1  data bit from B.
- c  input  1  data bit from C.
- gnt  output  3  registered one-hot grant, same bit order as req.
- sel  output  2  registered mux select: A=2'b10, B=2'b01, C=2'b00.
- sel_valid  output  1  high when gnt is nonzero.
- q  output  1  registered selected data bit.
- q_valid  output  1  q holds data sampled under a grant.
- q_src  output  2  owner of q, same encoding as sel.

Behaviour:
- Reset: all outputs are 0 (sel=2'b00). State=IDLE, hold_cnt=0, last=C.
  - Effect of last=C: the first priority order after reset is A,B,C.
  - rst asserted mid-grant clears everything on the next edge. There is no partial output.
- Round-robin order: after owner X is released, priority is X+1, X+2, X (cyclic A→B→C→A).
  - last updates only when a grant starts.
- States: IDLE, GRANT.
- IDLE:
  - gnt=0.
  - If req≠0, pick the winner by the RR order. Next edge: gnt=winner, sel=code(winner), hold_cnt=0, state=GRANT.
  - Latency from req to gnt is 1 cycle.
- GRANT, continue: if req[owner]=1 and hold_cnt<HOLD_MAX-1, keep the grant and increment hold_cnt.
- GRANT, release: release when req[owner]=0 or hold_cnt=HOLD_MAX-1. On the release edge:
  - Other requests pending: grant the next winner by RR order directly, with no idle cycle (back-to-back handoff), and reset hold_cnt to 0.
  - Only the same owner still requesting after a timeout: re-grant it. gnt stays high and hold_cnt resets to 0.
  - No requests: gnt=0, state=IDLE.
- A request that drops while its grant is already registered costs one wasted grant cycle. The grant drops on the next edge.
- Requests from non-owners never preempt before release.
- Data path: each cycle, q_valid<=sel_valid, q<=selected input per current sel, q_src<=sel.
  - Data latency is 1 cycle after the grant cycle.
  - When q_valid=0, q and q_src hold their last values.
- Invariants:
  - gnt is always one-hot or zero.
  - sel matches gnt; sel=2'b00 when gnt=0.
  - No starvation: any continuously asserted request is granted within 2×HOLD_MAX+1 cycles.

Optional Feature:
- Macro: MUX3_RR_GUARD_CYCLE_EN.
- When defined: a handoff between different owners inserts exactly one guard cycle with gnt=0 and sel_valid=0 (state GUARD). Arbitration for the next owner happens in the guard cycle using the then-current req.
  - Re-grant of the same owner after a timeout gets no guard cycle.
  - If no request is present in the guard cycle, go to IDLE.
- When undefined: handoff is back-to-back as described in Behaviour, and the GUARD state is absent.

Test Plan:
- Reset then req=3'b111 held, HOLD_MAX=4: expected gnt is A×4, B×4, C×4, A…; sel is 10,01,00 accordingly.
  - With the macro defined: one gnt=0 cycle between each owner.
- req=3'b010 pulse of 2 cycles from idle:
  - gnt=010 one cycle after req rises.
  - gnt held through the 1 extra cycle after req falls, then 000.
  - q_valid high for exactly the grant cycles, delayed by 1.
- req=3'b001 held alone for 10 cycles: gnt=001 continuously, with hold_cnt wrapping at 3. No gaps, even with the macro defined.
- Owner A granted with a=1; b toggling; req=3'b110:
  - q=1, q_src=10 for the A cycles, then q follows b one cycle late with q_src=01.
- rst pulsed for 1 cycle mid-grant of B:
  - Next cycle all outputs are 0.
  - Next grant order restarts at A when req=3'b111.
- Starvation check: random req with C held at 1 for 100 cycles. C is granted within 9 cycles every time.
